// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one N-bit timer among NREQ requesters.
// The winner's tick count is loaded into the timer, the timer runs until
// Tmr_End, and a one-cycle Done pulse goes back to the winner.
//
// Build option: define TIMER_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no pointer). Default is round-robin.
//
// state | meaning
// IDLE  | no grant; arbitrate among Req
// LOAD  | Tmr_Rst strobe, Tmr_Load = ticks-1
// RUN   | Tmr_En high, waiting for Tmr_End
// DONE  | one-cycle Done pulse to the winner
module timer_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NREQ-1:0]   Req,
  input  logic [NREQ*N-1:0] Ticks,
  output logic [NREQ-1:0]   Gnt,
  output logic [NREQ-1:0]   Done,
  output logic              Busy,
  output logic              Tmr_Rst,
  output logic [N-1:0]      Tmr_Load,
  output logic              Tmr_En,
  input  logic              Tmr_End
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic [N-1:0]    pick_ticks;
  logic            cancel;

`ifndef TIMER_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   ptr_nxt;
  logic [IW-1:0]   rr_j;
`endif

  // Winner selection; descending scan so the candidate closest to the
  // priority start is the last one written and wins.
  always_comb begin
    pick_vld   = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    pick_ticks = '0;
`ifdef TIMER_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (Req[k]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(k);
      end
    end
`else
    rr_j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rr_j = IW'((int'(ptr) + k) % NREQ);
      if (Req[rr_j]) begin
        pick_vld = 1'b1;
        pick_idx = rr_j;
      end
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == IW'(k)) begin
        pick_oh[k] = 1'b1;
        pick_ticks = Ticks[k*N +: N];
      end
    end
  end

  // The granted requester dropping its Req line is an abort.
  assign cancel = ~|(Req & Gnt);

`ifndef TIMER_ARB_FIXED_PRIO_EN
  assign ptr_nxt = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
`endif

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      Gnt      <= '0;
      Done     <= '0;
      Busy     <= 1'b0;
      Tmr_Rst  <= 1'b0;
      Tmr_Load <= '0;
      Tmr_En   <= 1'b0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
      ptr      <= '0;
      win_idx  <= '0;
`endif
    end else begin
      Done    <= '0;
      Tmr_Rst <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            Gnt  <= pick_oh;
            Busy <= 1'b1;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            win_idx <= pick_idx;
`endif
            if (pick_ticks == '0) begin
              // zero-length wait completes without touching the timer
              state <= DONE;
              Done  <= pick_oh;
            end else begin
              state    <= LOAD;
              Tmr_Rst  <= 1'b1;
              Tmr_Load <= pick_ticks - N'(1);
            end
          end
        end
        LOAD: begin
          if (cancel) begin
            state  <= IDLE;
            Gnt    <= '0;
            Busy   <= 1'b0;
            Tmr_En <= 1'b0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            ptr    <= ptr_nxt;
`endif
          end else begin
            state  <= RUN;
            Tmr_En <= 1'b1;
          end
        end
        RUN: begin
          if (cancel) begin
            state  <= IDLE;
            Gnt    <= '0;
            Busy   <= 1'b0;
            Tmr_En <= 1'b0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            ptr    <= ptr_nxt;
`endif
          end else if (Tmr_End) begin
            state  <= DONE;
            Tmr_En <= 1'b0;
            Done   <= Gnt;
          end
        end
        DONE: begin
          state <= IDLE;
          Gnt   <= '0;
          Busy  <= 1'b0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
          ptr   <= ptr_nxt;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
